// File: rtl/l2_way_lookup_pkg.sv
// Shared L2 tag-lookup constants and types.
package l2_way_lookup_pkg;

  localparam int unsigned L2_WAYS  = 4;
  localparam int unsigned L2_SETS  = 8;
  localparam int unsigned L2_TAG_W = 9;
  localparam int unsigned L2_SET_W = $clog2(L2_SETS);
  localparam int unsigned L2_WAY_W = $clog2(L2_WAYS);

  typedef logic [L2_TAG_W-1:0] lc3b_c2_tag;
  typedef logic [L2_SET_W-1:0] lc3b_c2_set_idx;
  typedef logic [L2_WAY_W-1:0] lc3b_c2_way_idx;
  typedef logic [L2_WAYS-1:0]  lc3b_c2_way_vec;

endpackage

// File: rtl/l2_way_lookup_plru_tree.sv
// Combinational tree-PLRU helper: victim pick from the current state, and the
// next state after touching one way. Node 0 is the root, children of n are
// 2n+1 (lower half) and 2n+2 (upper half); a 0 bit points at the lower half.
module plru_tree #(
  parameter int unsigned WAYS = 4
) (
  input  logic [WAYS-2:0]         state_i,
  input  logic [$clog2(WAYS)-1:0] way_i,
  output logic [WAYS-2:0]         next_o,
  output logic [WAYS-1:0]         victim_o
);

  localparam int unsigned WAY_W = $clog2(WAYS);

  logic [WAY_W-1:0] upd_node;
  logic [WAY_W-1:0] vic_node;
  logic [WAY_W-1:0] vic_idx;
  logic             dir;
  logic             vbit;

  // Walk the accessed way's path, flipping each node to point away from it,
  // and walk the stored pointers from the root to form the victim index.
  always_comb begin
    next_o   = state_i;
    upd_node = '0;
    vic_node = '0;
    vic_idx  = '0;
    dir      = 1'b0;
    vbit     = 1'b0;
    for (int unsigned lvl = 0; lvl < WAY_W; lvl++) begin
      dir              = way_i[WAY_W-1-lvl];
      next_o[upd_node] = ~dir;
      upd_node         = (upd_node << 1) + WAY_W'(1) + WAY_W'(dir);

      vbit                 = state_i[vic_node];
      vic_idx[WAY_W-1-lvl] = vbit;
      vic_node             = (vic_node << 1) + WAY_W'(1) + WAY_W'(vbit);
    end
    victim_o = WAYS'(1) << vic_idx;
  end

endmodule

// File: rtl/l2_way_lookup.sv
// N-way L2 tag lookup with registered hit/way/victim response and
// tree-PLRU replacement. Fill and invalidate come from the L2 controller.
module l2_way_lookup
  import l2_way_lookup_pkg::*;
#(
  parameter int unsigned WAYS  = L2_WAYS,
  parameter int unsigned SETS  = L2_SETS,
  parameter int unsigned TAG_W = L2_TAG_W,
  parameter int unsigned SET_W = $clog2(SETS),
  parameter int unsigned WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             lookup_req,
  input  logic [SET_W-1:0] lookup_set,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             resp_valid,
  output logic             resp_hit,
  output logic [WAYS-1:0]  resp_way,
  output logic [WAYS-1:0]  resp_victim,
  output logic             resp_multi_hit,
  input  logic             fill_en,
  input  logic [SET_W-1:0] fill_set,
  input  logic [WAY_W-1:0] fill_way,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic             inval_en,
  input  logic [SET_W-1:0] inval_set
);

  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAYS-2:0]  plru_q  [SETS];

  logic             resp_valid_q, resp_hit_q, resp_multi_q;
  logic [WAYS-1:0]  resp_way_q, resp_victim_q;

  logic [WAYS-1:0]  lk_valid, hit_vec, hit_low, inv_vec, inv_low;
  logic [WAYS-1:0]  victim_d, plru_victim;
  logic             hit_d, multi_d;
  logic [WAY_W-1:0] hit_idx;
  logic [WAYS-2:0]  lk_state, lk_next, fill_base, fill_next;

  plru_tree #(.WAYS(WAYS)) u_plru_lookup (
    .state_i  (lk_state),
    .way_i    (hit_idx),
    .next_o   (lk_next),
    .victim_o (plru_victim)
  );

  plru_tree #(.WAYS(WAYS)) u_plru_fill (
    .state_i  (fill_base),
    .way_i    (fill_way),
    .next_o   (fill_next),
    .victim_o ()
  );

  // Tag compare, lowest-index hit/invalid pick and victim select on pre-edge state.
  always_comb begin
    lk_valid = valid_q[lookup_set];
    lk_state = plru_q[lookup_set];
    hit_vec  = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      hit_vec[w] = lk_valid[w] && (tag_q[lookup_set][w] == lookup_tag);
    end
    hit_low  = hit_vec & (~hit_vec + WAYS'(1));
    hit_d    = |hit_vec;
    multi_d  = |(hit_vec & (hit_vec - WAYS'(1)));
    inv_vec  = ~lk_valid;
    inv_low  = inv_vec & (~inv_vec + WAYS'(1));
    victim_d = (|inv_vec) ? inv_low : plru_victim;
    hit_idx  = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (hit_low[w]) hit_idx = WAY_W'(w);
    end
    // Fill update is layered on top of a same-set hit update so fill wins shared nodes.
    fill_base = (lookup_req && hit_d && (lookup_set == fill_set)) ? lk_next : plru_q[fill_set];
  end

  // Tag storage: written on fill, intentionally not reset.
  always_ff @(posedge clk) begin
    if (fill_en) tag_q[fill_set][fill_way] <= fill_tag;
  end

  // Valid/PLRU state and registered response; fill follows inval so its way ends valid.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
      resp_valid_q  <= 1'b0;
      resp_hit_q    <= 1'b0;
      resp_multi_q  <= 1'b0;
      resp_way_q    <= '0;
      resp_victim_q <= '0;
    end else begin
      resp_valid_q <= lookup_req;
      if (lookup_req) begin
        resp_hit_q    <= hit_d;
        resp_multi_q  <= multi_d;
        resp_way_q    <= hit_low;
        resp_victim_q <= victim_d;
        if (hit_d) plru_q[lookup_set] <= lk_next;
      end
      if (inval_en) valid_q[inval_set] <= '0;
      if (fill_en) begin
        valid_q[fill_set][fill_way] <= 1'b1;
        plru_q[fill_set]            <= fill_next;
      end
    end
  end

  assign resp_valid     = resp_valid_q;
  assign resp_hit       = resp_hit_q;
  assign resp_way       = resp_way_q;
  assign resp_victim    = resp_victim_q;
  assign resp_multi_hit = resp_multi_q;

endmodule

// File: doc/l2_way_lookup.md
Name: l2_way_lookup

Overview:
- Parametrised N-way tag lookup and replacement unit for the L2 cache. Replaces the fixed 4-way combinational hit detector.
- Holds the per-set tag, valid and tree-PLRU state internally and accepts one lookup per cycle.
- Returns a registered hit/way/victim response one cycle later; fill and invalidate ports are driven by the L2 controller FSM.
- Sits between the L2 controller and the L2 data arrays.

Parameters:
- WAYS, 4, associativity; power of two, 2..16
- SETS, 8, number of sets; power of two, ≥2
- TAG_W, 9, tag width in bits
- (derived) SET_W = $clog2(SETS), WAY_W = $clog2(WAYS)

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- lookup_req  in  1  lookup request valid this cycle
- lookup_set  in  SET_W  set index of lookup
- lookup_tag  in  TAG_W  tag to compare
- resp_valid  out  1  response valid (one cycle after lookup_req)
- resp_hit  out  1  tag matched a valid way
- resp_way  out  WAYS  one-hot hit way; zero on miss
- resp_victim  out  WAYS  one-hot replacement way for the looked-up set
- resp_multi_hit  out  1  more than one valid way matched (error flag)
- fill_en  in  1  write tag into a way and mark it valid
- fill_set  in  SET_W  fill set index
- fill_way  in  WAY_W  fill way index
- fill_tag  in  TAG_W  tag written
- inval_en  in  1  clear all valid bits of inval_set
- inval_set  in  SET_W  invalidate set index

Behaviour:
- Reset (reset_n=0 at a rising clk): all valid bits cleared, all PLRU bits 0, resp_valid/resp_hit/resp_multi_hit=0, resp_way=0, resp_victim=0. Tag storage is not reset. Reset mid-lookup drops the pending response.
- Latency: compare happens combinationally in the request cycle against array state as it stands before that edge; results register at the edge; resp_* valid for exactly one cycle. Back-to-back lookups give back-to-back responses. When lookup_req=0, resp_valid=0 next cycle and the other resp_* outputs hold their last values.
- Hit: a way hits when its valid bit=1 and its tag==lookup_tag. resp_way selects the lowest-index hitting way. resp_multi_hit=1 when two or more ways hit.
- Victim selection:
  - If any way in the set is invalid, the victim is the lowest-index invalid way.
  - Otherwise the victim is the tree-PLRU pick.
  - resp_victim is computed on both hit and miss.
- Tree-PLRU: WAYS-1 bits per set, heap-ordered with node 0 as root. Bit=0 means the victim lies in the lower half. Traversing from the root gives the victim.
- PLRU update on access: each node on the accessed way's path is set to point away from that way.
- PLRU updates:
  - On a hit, the hit way's path updates at the lookup edge.
  - On fill_en, fill_way's path updates.
  - If hit and fill target the same set in the same cycle, apply the hit update first and the fill update last; fill bits win on shared nodes.
- Fill: at the edge, tag[fill_set][fill_way]=fill_tag and valid=1.
- Invalidate: at the edge, all valid bits of inval_set=0; PLRU bits are untouched.
- Same-cycle fill and inval to the same set: inval clears the set, then the fill's way is set valid; the filled way ends valid.
- Same-cycle lookup and fill/inval to the same set: the lookup sees pre-update state, i.e. no bypass. The controller must not rely on forwarding.
- All set/way indices are in range by construction; there is no wrap-around or overflow.

Decomposition:
- lc3b_types gains:
  - lc3b_c2_tag, redefined from TAG_W = 9
  - lc3b_c2_set_idx
  - constants L2_WAYS=4 and L2_SETS=8
- Sub-module plru_tree: a purely combinational function block, parametrised by WAYS.
  - Input: state bits and access way; outputs: next state and victim one-hot.
  - Instantiated twice, once for the lookup path and once for the fill path.

Test Plan:
- Reset then lookup set 3, tag 0x055 -> next cycle resp_valid=1, resp_hit=0, resp_way=0000, resp_victim=0001.
- Fill set 3, ways 0..3, tags 0x10..0x13; lookup set 3, tag 0x12 -> resp_hit=1, resp_way=0100, resp_multi_hit=0.
- With set 3 full and PLRU=000, hit way 0, then way 2 -> next lookup miss gives resp_victim=0010 (way 1).
- Fill set 5 way 1 and way 3 both with tag 0x0AA, lookup 0x0AA -> resp_way=0010, resp_multi_hit=1.
- Lookup set 2 tag 0x20 in the same cycle as fill set 2 way 0 tag 0x20 -> resp_hit=0; repeating the lookup the next cycle -> resp_hit=1, resp_way=0001.
- Inval set 3 with fill set 3 way 2 in the same cycle -> a lookup of way 2's tag hits, a lookup of way 0's old tag misses, and resp_victim=0001. Asserting reset_n=0 the cycle after a lookup_req -> resp_valid=0.
